// File: rtl/pipe_hazard_ctl.sv
// Pipeline hazard controller for the five-stage MIPS core.
// It handles load-use bubbles, taken-branch squashes and data-memory wait
// freezes, and it keeps saturating performance counters.
module pipe_hazard_ctl #(
  parameter int unsigned LOAD_STALLS = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_use_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             exmem_branch,
  input  logic             exmem_zero,
  input  logic             exmem_memacc,
  input  logic             dmem_ready,
  input  logic             cnt_clr,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             pcsrc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] wait_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, LDSTALL, MEMWAIT} state_t;
  typedef enum logic [1:0] {A_PASS, A_FREEZE, A_FLUSH, A_STALL} act_t;

  state_t     state, state_nxt;
  state_t     ret, ret_nxt;
  state_t     eff;
  logic [1:0] rem, rem_nxt;
  act_t       act;
  logic       lu, tb, mw;
  logic       inc_stall, inc_wait, inc_flush;

  // Raw hazard terms from the current pipeline contents.
  always_comb begin
    lu = idex_memread && (idex_rt != '0) &&
         ((idex_rt == ifid_rs) || (ifid_use_rt && (idex_rt == ifid_rt)));
    tb = exmem_branch && exmem_zero;
    mw = exmem_memacc && !dmem_ready;
  end

  // State, remaining-stall and resume registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      rem   <= '0;
      ret   <= RUN;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      ret   <= ret_nxt;
    end
  end

  // Next-state and action decode; MEMWAIT resolves to its resume state as
  // soon as memory is ready, so that cycle decodes as RUN or LDSTALL directly.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    ret_nxt   = ret;
    act       = A_PASS;
    inc_stall = 1'b0;
    inc_wait  = 1'b0;
    inc_flush = 1'b0;
    eff       = (state == MEMWAIT) ? ret : state;

    if (mw) begin
      act      = A_FREEZE;
      inc_wait = 1'b1;
      if (state != MEMWAIT) begin
        ret_nxt   = state;
        state_nxt = MEMWAIT;
      end
    end else if (eff == LDSTALL) begin
      if (tb) begin
        act       = A_FLUSH;
        inc_flush = 1'b1;
        rem_nxt   = '0;
        state_nxt = RUN;
      end else begin
        act       = A_STALL;
        inc_stall = 1'b1;
        rem_nxt   = rem - 2'd1;
        state_nxt = (rem == 2'd1) ? RUN : LDSTALL;
      end
    end else begin
      state_nxt = RUN;
      if (tb) begin
        act       = A_FLUSH;
        inc_flush = 1'b1;
      end else if (lu) begin
        act       = A_STALL;
        inc_stall = 1'b1;
        if (LOAD_STALLS > 1) begin
          rem_nxt   = 2'(LOAD_STALLS - 1);
          state_nxt = LDSTALL;
        end
      end
    end
  end

  // Latch controls from the decoded action, forced low while in reset.
  always_comb begin
    pc_en        = 1'b0;
    ifid_en      = 1'b0;
    idex_en      = 1'b0;
    exmem_en     = 1'b0;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    pcsrc        = 1'b0;
    case (act)
      A_PASS: begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
      end
      A_FLUSH: begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        idex_en      = 1'b1;
        exmem_en     = 1'b1;
        ifid_flush   = 1'b1;
        idex_bubble  = 1'b1;
        exmem_bubble = 1'b1;
        pcsrc        = 1'b1;
      end
      A_STALL: begin
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        idex_bubble = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      ifid_flush   = 1'b0;
      idex_bubble  = 1'b0;
      exmem_bubble = 1'b0;
      pcsrc        = 1'b0;
    end
  end

  // Saturating performance counters; clear overrides any increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      wait_cnt  <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      wait_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      if (inc_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (inc_wait  && (wait_cnt  != '1)) wait_cnt  <= wait_cnt  + CNT_W'(1);
      if (inc_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Testbench for pipe_hazard_ctl: two instances (1 bubble / 16-bit counters and
// 3 bubbles / 2-bit counters) share stimulus and are compared against a
// pending-bubble reference model, a constant vector table and hand sequences.
module tb_pipe_hazard_ctl;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rt;
    logic       memread;
    logic [4:0] idex_rt;
    logic       branch;
    logic       zero;
    logic       memacc;
    logic       ready;
    logic       clr;
  } in_t;

  typedef struct {
    in_t        i;
    logic [7:0] ctl;
    int         s;
    int         w;
    int         f;
  } vec_t;

  typedef struct {
    int pending;
    int stall;
    int waitc;
    int flush;
  } mstate_t;

  localparam logic [7:0] C_RUN    = 8'hF0;
  localparam logic [7:0] C_FREEZE = 8'h00;
  localparam logic [7:0] C_FLUSH  = 8'hFF;
  localparam logic [7:0] C_STALL  = 8'h34;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic ifid_use_rt, idex_memread, exmem_branch, exmem_zero, exmem_memacc;
  logic dmem_ready, cnt_clr;

  logic a_pc, a_ifid, a_idex, a_exmem, a_fl, a_idb, a_exb, a_pcsrc;
  logic b_pc, b_ifid, b_idex, b_exmem, b_fl, b_idb, b_exb, b_pcsrc;
  logic [15:0] a_stall, a_wait, a_flush;
  logic [1:0]  b_stall, b_wait, b_flush;
  logic [7:0]  ctl1, ctl3;

  int vectors = 0;
  int miscompares = 0;
  mstate_t m1, m3;
  in_t cur;
  vec_t tbl[20];

  assign ctl1 = {a_pc, a_ifid, a_idex, a_exmem, a_fl, a_idb, a_exb, a_pcsrc};
  assign ctl3 = {b_pc, b_ifid, b_idex, b_exmem, b_fl, b_idb, b_exb, b_pcsrc};

  always #5 clk = ~clk;

  pipe_hazard_ctl #(.LOAD_STALLS(1), .CNT_W(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_use_rt(ifid_use_rt),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
    .exmem_memacc(exmem_memacc), .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
    .pc_en(a_pc), .ifid_en(a_ifid), .idex_en(a_idex), .exmem_en(a_exmem),
    .ifid_flush(a_fl), .idex_bubble(a_idb), .exmem_bubble(a_exb), .pcsrc(a_pcsrc),
    .stall_cnt(a_stall), .wait_cnt(a_wait), .flush_cnt(a_flush)
  );

  pipe_hazard_ctl #(.LOAD_STALLS(3), .CNT_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_use_rt(ifid_use_rt),
    .idex_memread(idex_memread), .idex_rt(idex_rt),
    .exmem_branch(exmem_branch), .exmem_zero(exmem_zero),
    .exmem_memacc(exmem_memacc), .dmem_ready(dmem_ready), .cnt_clr(cnt_clr),
    .pc_en(b_pc), .ifid_en(b_ifid), .idex_en(b_idex), .exmem_en(b_exmem),
    .ifid_flush(b_fl), .idex_bubble(b_idb), .exmem_bubble(b_exb), .pcsrc(b_pcsrc),
    .stall_cnt(b_stall), .wait_cnt(b_wait), .flush_cnt(b_flush)
  );

  function automatic in_t mk(input int rs, input int rt, input int ur, input int mr,
                             input int irt, input int br, input int z, input int ma,
                             input int rdy, input int clr);
    in_t x;
    x.rs      = 5'(rs);
    x.rt      = 5'(rt);
    x.use_rt  = 1'(ur);
    x.memread = 1'(mr);
    x.idex_rt = 5'(irt);
    x.branch  = 1'(br);
    x.zero    = 1'(z);
    x.memacc  = 1'(ma);
    x.ready   = 1'(rdy);
    x.clr     = 1'(clr);
    return x;
  endfunction

  function automatic bit f_lu(input in_t x);
    return x.memread && (x.idex_rt != 0) &&
           ((x.idex_rt == x.rs) || (x.use_rt && (x.idex_rt == x.rt)));
  endfunction

  // Reference: owed bubbles are a plain count; a memory wait simply pauses.
  function automatic logic [7:0] f_ctl(input mstate_t m, input in_t x);
    if (x.memacc && !x.ready) return C_FREEZE;
    if (x.branch && x.zero) return C_FLUSH;
    if (m.pending > 0 || f_lu(x)) return C_STALL;
    return C_RUN;
  endfunction

  function automatic mstate_t f_next(input mstate_t m, input in_t x, input int n, input int w);
    mstate_t r = m;
    int mx = (1 << w) - 1;
    if (x.memacc && !x.ready) begin
      r.waitc = (m.waitc < mx) ? m.waitc + 1 : mx;
    end else if (x.branch && x.zero) begin
      r.flush = (m.flush < mx) ? m.flush + 1 : mx;
      r.pending = 0;
    end else if (m.pending > 0 || f_lu(x)) begin
      r.stall = (m.stall < mx) ? m.stall + 1 : mx;
      r.pending = (m.pending > 0) ? m.pending - 1 : n - 1;
    end
    if (x.clr) begin
      r.stall = 0;
      r.waitc = 0;
      r.flush = 0;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input in_t x);
    ifid_rs      = x.rs;
    ifid_rt      = x.rt;
    ifid_use_rt  = x.use_rt;
    idex_memread = x.memread;
    idex_rt      = x.idex_rt;
    exmem_branch = x.branch;
    exmem_zero   = x.zero;
    exmem_memacc = x.memacc;
    dmem_ready   = x.ready;
    cnt_clr      = x.clr;
    cur          = x;
  endtask

  task automatic check_models();
    chk("ctl1", 32'(ctl1), 32'(f_ctl(m1, cur)));
    chk("stall1", 32'(a_stall), m1.stall);
    chk("wait1", 32'(a_wait), m1.waitc);
    chk("flush1", 32'(a_flush), m1.flush);
    chk("ctl3", 32'(ctl3), 32'(f_ctl(m3, cur)));
    chk("stall3", 32'(b_stall), m3.stall);
    chk("wait3", 32'(b_wait), m3.waitc);
    chk("flush3", 32'(b_flush), m3.flush);
  endtask

  task automatic apply(input in_t x);
    @(negedge clk);
    drive(x);
    #1;
    check_models();
  endtask

  task automatic commit();
    @(posedge clk);
    m1 = f_next(m1, cur, 1, 16);
    m3 = f_next(m3, cur, 3, 2);
  endtask

  // Asynchronous reset pulse in the middle of a cycle, then one idle cycle.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst ctl1", 32'(ctl1), 0);
    chk("rst ctl3", 32'(ctl3), 0);
    chk("rst cnt1", {a_stall, a_wait[7:0], a_flush[7:0]}, 0);
    chk("rst cnt3", 32'({b_stall, b_wait, b_flush}), 0);
    m1 = '{0, 0, 0, 0};
    m3 = '{0, 0, 0, 0};
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    #1;
    check_models();
    commit();
  endtask

  initial begin
    in_t idle, lu5, mwx, tbmw, tbr, x;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    lu5  = mk(5, 0, 0, 1, 5, 0, 0, 0, 1, 0);
    mwx  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbmw = mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    tbr  = mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 0);

    tbl[0]  = '{idle,                              C_RUN,    0, 0, 0};
    tbl[1]  = '{lu5,                               C_STALL,  0, 0, 0};
    tbl[2]  = '{idle,                              C_RUN,    1, 0, 0};
    tbl[3]  = '{mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0),  C_RUN,    1, 0, 0};
    tbl[4]  = '{mk(3, 7, 0, 1, 7, 0, 0, 0, 1, 0),  C_RUN,    1, 0, 0};
    tbl[5]  = '{mk(3, 7, 1, 1, 7, 0, 0, 0, 1, 0),  C_STALL,  1, 0, 0};
    tbl[6]  = '{mk(0, 0, 0, 0, 0, 1, 1, 0, 1, 0),  C_FLUSH,  2, 0, 0};
    tbl[7]  = '{mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0),  C_RUN,    2, 0, 1};
    tbl[8]  = '{mk(5, 0, 0, 1, 5, 1, 1, 0, 1, 0),  C_FLUSH,  2, 0, 1};
    tbl[9]  = '{mwx,                               C_FREEZE, 2, 0, 2};
    tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0),  C_RUN,    2, 1, 2};
    tbl[11] = '{tbmw,                              C_FREEZE, 2, 1, 2};
    tbl[12] = '{tbmw,                              C_FREEZE, 2, 2, 2};
    tbl[13] = '{tbr,                               C_FLUSH,  2, 3, 2};
    tbl[14] = '{idle,                              C_RUN,    2, 3, 3};
    tbl[15] = '{mk(5, 0, 0, 1, 5, 0, 0, 1, 0, 0),  C_FREEZE, 2, 3, 3};
    tbl[16] = '{mk(5, 0, 0, 1, 5, 0, 0, 1, 1, 0),  C_STALL,  2, 4, 3};
    tbl[17] = '{idle,                              C_RUN,    3, 4, 3};
    tbl[18] = '{mk(5, 0, 0, 1, 5, 0, 0, 0, 1, 1),  C_STALL,  3, 4, 3};
    tbl[19] = '{idle,                              C_RUN,    0, 0, 0};

    rst_n = 1'b0;
    drive(idle);
    m1 = '{0, 0, 0, 0};
    m3 = '{0, 0, 0, 0};
    do_reset();

    // Constant vector table against the single-bubble instance.
    for (int k = 0; k < 20; k++) begin
      apply(tbl[k].i);
      chk($sformatf("tbl%0d ctl", k), 32'(ctl1), 32'(tbl[k].ctl));
      chk($sformatf("tbl%0d cnt", k), {a_stall[7:0], a_wait[7:0], a_flush[7:0]},
          {8'(tbl[k].s), 8'(tbl[k].w), 8'(tbl[k].f)});
      commit();
    end

    // Memory wait inside a three-bubble stall.
    do_reset();
    apply(lu5);  chk("mw-in-stall c1", 32'(ctl3), 32'(C_STALL));  commit();
    apply(mwx);  chk("mw-in-stall c2", 32'(ctl3), 32'(C_FREEZE)); commit();
    apply(mwx);  chk("mw-in-stall c3", 32'(ctl3), 32'(C_FREEZE)); commit();
    apply(idle); chk("mw-in-stall c4", 32'(ctl3), 32'(C_STALL));  commit();
    apply(idle); chk("mw-in-stall c5", 32'(ctl3), 32'(C_STALL));  commit();
    apply(idle); chk("mw-in-stall c6", 32'(ctl3), 32'(C_RUN));
    chk("mw-in-stall cnt", 32'({b_stall, b_wait, b_flush}), 32'({2'd3, 2'd2, 2'd0}));
    commit();

    // Simultaneous taken branch and memory wait.
    do_reset();
    apply(tbmw); chk("tb+mw c1", 32'(ctl1), 32'(C_FREEZE)); commit();
    apply(tbmw); chk("tb+mw c2", 32'(ctl1), 32'(C_FREEZE)); commit();
    apply(tbr);  chk("tb+mw c3", 32'(ctl1), 32'(C_FLUSH));  commit();
    apply(idle); chk("tb+mw c4", 32'(ctl1), 32'(C_RUN));
    chk("tb+mw flush", 32'(a_flush), 1);
    chk("tb+mw wait", 32'(a_wait), 2);
    commit();

    // Saturation of a 2-bit stall counter over six bubbles.
    do_reset();
    apply(lu5);  commit();
    apply(idle); commit();
    apply(idle); commit();
    apply(lu5);  chk("sat stall4", 32'(ctl3), 32'(C_STALL)); commit();
    apply(idle); commit();
    apply(idle); commit();
    apply(idle); chk("sat cnt", 32'(b_stall), 3); commit();

    // Clear coinciding with an increment.
    x = lu5;
    x.clr = 1'b1;
    apply(x);    chk("clr+inc ctl", 32'(ctl3), 32'(C_STALL)); commit();
    apply(idle); chk("clr+inc cnt", 32'({b_stall, b_wait, b_flush}), 0); commit();
    apply(idle); commit();

    // Reset in the middle of a stall drops the owed bubbles.
    apply(lu5);  commit();
    apply(idle); chk("pre-rst stall", 32'(ctl3), 32'(C_STALL)); commit();
    do_reset();
    apply(idle); chk("post-rst run", 32'(ctl3), 32'(C_RUN)); commit();

    // Randomised traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      x = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
             ($urandom_range(0, 1)), $urandom_range(0, 3),
             ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 1),
             ($urandom_range(0, 9) < 3) ? 1 : 0, ($urandom_range(0, 9) < 6) ? 1 : 0,
             ($urandom_range(0, 31) == 0) ? 1 : 0);
      apply(x);
      commit();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctl.md
# pipe_hazard_ctl

Pipeline hazard controller for the five-stage MIPS core. It drives the write-enables and bubble/flush controls of the PC, IF/ID, ID/EX and EX/MEM latches. It detects load-use hazards and inserts a configurable number of bubbles, and it squashes wrong-path instructions on a taken branch resolved at the EX/MEM latch. It freezes the whole pipeline while data memory is not ready, and it keeps saturating performance counters.

## Interface
- LOAD_STALLS, 1: bubbles inserted per load-use hazard; legal 1..3
- CNT_W, 16: width of each performance counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- ifid_rs  in  5  rs field of the IF/ID instruction
- ifid_rt  in  5  rt field of the IF/ID instruction
- ifid_use_rt  in  1  IF/ID instruction reads rt
- idex_memread  in  1  ID/EX m_ctlout[1] (memread)
- idex_rt  in  5  ID/EX instrout_2016 (load destination)
- exmem_branch  in  1  EX/MEM m_ctlout[2] (branch)
- exmem_zero  in  1  EX/MEM zero
- exmem_memacc  in  1  EX/MEM memread OR memwrite
- dmem_ready  in  1  data memory completes the access this cycle
- cnt_clr  in  1  synchronous clear of all counters
- pc_en, ifid_en, idex_en, exmem_en  out  1 each  latch write-enables
- ifid_flush  out  1  load a NOP into IF/ID
- idex_bubble  out  1  zero wb_ctl, m_ctl and ex_ctl written into ID/EX
- exmem_bubble  out  1  zero wb_ctl and m_ctl written into EX/MEM
- pcsrc  out  1  select the branch target (add_result) for PC
- stall_cnt, wait_cnt, flush_cnt  out  CNT_W each  performance counters

## Operation
- Hazard terms:
  - lu = idex_memread & (idex_rt != 0) & ((idex_rt == ifid_rs) | (ifid_use_rt & idex_rt == ifid_rt))
  - tb = exmem_branch & exmem_zero
  - mw = exmem_memacc & ~dmem_ready
- Default (no event): all enables 1; flush, bubbles and pcsrc 0.
- Internal registers:
  - state: RUN, LDSTALL or MEMWAIT
  - rem: remaining stall cycles, 2 bits
  - ret: resume state
- Event priority in every state is mw > tb > lu.
- **RUN:**
  - mw: freeze. All enables 0, bubbles and flush 0, pcsrc 0. ret<=RUN, state<=MEMWAIT, wait_cnt+1.
  - tb: pcsrc=1, ifid_flush=1, idex_bubble=1, exmem_bubble=1, all enables 1, flush_cnt+1. Any lu is ignored because the dependent instruction is squashed.
  - lu: pc_en=0, ifid_en=0, idex_bubble=1, idex_en=1, exmem_en=1, stall_cnt+1. If LOAD_STALLS>1: rem<=LOAD_STALLS-1, state<=LDSTALL.
- **LDSTALL:** same outputs as the lu case, regardless of lu; stall_cnt+1; rem<=rem-1.
  - State goes to RUN when rem==1 this cycle.
  - mw: freeze, rem held, ret<=LDSTALL, state<=MEMWAIT.
  - tb: behaves as tb in RUN, rem<=0, state<=RUN.
- **MEMWAIT:**
  - While mw: freeze, wait_cnt+1.
  - First cycle with mw=0: outputs and transitions are exactly those of state ret, evaluated this same cycle. There is no extra dead cycle.
- Counters saturate at all-ones and never wrap. When cnt_clr is 1, all three load 0 at the edge, overriding any increment.

## Timing
- All control outputs are combinational from state and current inputs. The latches act on them at the next rising edge, so hazard response latency is 0 cycles.
- state, rem, ret and the counters update on the rising clk edge.
- Reset behaviour, while rst_n=0:
  - state=RUN, rem=0, ret=RUN, counters=0.
  - All enables, flush, bubbles and pcsrc are forced to 0; output gating by rst_n is asynchronous.
- First edge after deassertion: RUN decode.
- Reset mid-stall or mid-wait: abandon immediately; no pending bubbles survive.
- One lu event with LOAD_STALLS=N gives exactly N bubble cycles, plus any MEMWAIT freeze cycles inserted between them.
- tb and mw in the same cycle: freeze only. The branch is taken on the first non-waiting cycle; flush_cnt increments once.

## Test plan
- **Load-use stall:** LOAD_STALLS=1, idex_memread=1, idex_rt=5, ifid_rs=5 -> one cycle of pc_en=0, ifid_en=0, idex_bubble=1, then all enables 1; stall_cnt=1.
- **Register $0:** idex_rt=0, ifid_rs=0, idex_memread=1 -> no stall. With ifid_use_rt=0 and only ifid_rt matching -> no stall.
- **Taken branch:** exmem_branch=1, exmem_zero=1 -> pcsrc=1, ifid_flush=1, idex_bubble=1, exmem_bubble=1 for one cycle; flush_cnt=1. With exmem_zero=0 -> no action.
- **Memory wait inside a stall:** LOAD_STALLS=3, lu, then mw for 2 cycles during LDSTALL -> 3 bubble cycles total, 2 freeze cycles; wait_cnt=2, stall_cnt=3.
- **Simultaneous tb and mw:** tb=1 and mw=1 for 2 cycles, then dmem_ready=1 -> 2 freeze cycles, then the flush cycle; flush_cnt=1.
- **Reset and counter edges:** pull rst_n low mid-LDSTALL -> all outputs 0 asynchronously, counters 0. Preload counter to all-ones via CNT_W=2 with 4 stalls -> stall_cnt stays 3. cnt_clr together with an increment -> 0.
